rv_mem_arbiter: RTL and testbench
=================================

// Module: rv_mem_arbiter
// PURPOSE
//  Shares the single 32-bit iosys memory port (rv_valid/rv_ready, 8MB space) among three masters:
//  m0 = flash firmware loader, m1 = picorv32 core, m2 = savestate/DMA engine.
//  Sits between the iosys masters and the SDRAM controller port, replacing the loader/CPU mux.
//  Fixed priority for m0; m1/m2 round-robin; per-transaction timeout with error reporting.
// PARAMETERS
//  TIMEOUT    4096          max cycles from rv_valid rise to rv_ready before abort (>=2)
//  ERR_DATA   32'hDEAD_BEEF read data returned on an aborted transaction
// PORTS
//  clk        in   1   system clock (NES mclk); single clock domain
//  reset      in   1   asynchronous, active-high reset
//  mN_valid   in   1   N=0..2: request; held high until the matching mN_ready
//  mN_addr    in   23  N=0..2: byte address
//  mN_wdata   in   32  N=0..2: write data
//  mN_wstrb   in   4   N=0..2: byte strobes; 0 = read
//  mN_ready   out  1   N=0..2: one-cycle completion pulse
//  m_rdata    out  32  read data, shared by all masters; valid while any mN_ready is high
//  rv_valid   out  1   downstream request
//  rv_addr    out  23  downstream address
//  rv_wdata   out  32  downstream write data
//  rv_wstrb   out  4   downstream strobes
//  rv_ready   in   1   downstream completion pulse
//  rv_rdata   in   32  downstream read data, valid with rv_ready
//  grant      out  3   one-hot owner of the current transaction; 0 when IDLE
//  err        out  1   sticky timeout flag
//  err_port   out  2   master of the last timeout
//  err_clr    in   1   clears err; err_port is kept
// BEHAVIOUR
//  Reset (async): state=IDLE; rv_valid=0; rv_addr/wdata/wstrb=0; all mN_ready=0; m_rdata=0;
//    grant=0; err=0; err_port=0; rr_next=1. Reset during ISSUE drops rv_valid immediately.
//    No ready pulse is produced for the interrupted request.
//  FSM: IDLE -> ISSUE -> RESP -> IDLE. All outputs are registered.
//  IDLE: sample the valids. Winner = m0 if m0_valid. Otherwise rr_next if its valid is high.
//    Otherwise the other of m1/m2.
//    On a win: latch addr/wdata/wstrb, set grant, rv_valid<=1, clear tcnt, go to ISSUE.
//  ISSUE: rv_valid stays high and the latched fields are frozen.
//    Changes on the requester inputs are ignored.
//  ISSUE exit on rv_ready: m_rdata<=rv_rdata; rv_valid<=0; go to RESP.
//  ISSUE timeout: tcnt increments each cycle. At tcnt==TIMEOUT-1 without rv_ready:
//    rv_valid<=0; m_rdata<=ERR_DATA; err<=1; err_port<=owner; go to RESP.
//  RESP: mN_ready=1 for the owner only, for exactly one cycle. m_rdata holds its value.
//    Then grant<=0 and go to IDLE. If the owner was m1/m2, rr_next<=the other one.
//  Turnaround: the master drops valid after seeing ready, so IDLE never re-grants a stale request.
//  Latency: request seen in IDLE at cycle t -> rv_valid at t+1. rv_ready at cycle u -> mN_ready at u+1.
//  Minimum 3 cycles per transaction.
//  m0 can starve m1/m2; this is intended, because the loader runs before the CPU is released.
//  rv_ready outside ISSUE is ignored. err_clr and a timeout in the same cycle: set wins.
//  tcnt width = $clog2(TIMEOUT); wrap is impossible because the counter exits at TIMEOUT-1.
// STRUCTURE
//  Shared header iosys_defs.vh: RV_AW=23, state encodings, default ERR_DATA.
//  One combinational sub-module rv_arb_pick: valids[2:0] + rr_next -> one-hot winner.
//  FSM, latches and timeout counter live in the top.
// TESTING
//  1 m1 read 0x000100, rv_ready 3 cycles after rv_valid, rv_rdata=0x12345678
//    -> rv_valid 3 cycles; one m1_ready pulse; m_rdata=0x12345678; m0/m2_ready stay 0.
//  2 m0,m1,m2 valid in the same cycle -> grants 0,1,2. With m1,m2 held continuously -> 1,2,1,2.
//  3 m2 write: addr 0x7F0004, wdata 0xA5A5A5A5, wstrb 4'b0100; m2 changes wdata during ISSUE
//    -> rv_* carry the latched values.
//  4 TIMEOUT=16, rv_ready never arrives -> rv_valid drops after 16 cycles;
//    m1_ready with m_rdata=0xDEADBEEF; err=1, err_port=1. Then err_clr -> err=0.
//  5 reset pulse mid-ISSUE -> rv_valid=0 asynchronously; no mN_ready after release; next grant OK.
//  6 rv_ready pulse while IDLE -> no mN_ready and no state change.

Source files
------------

// File: rtl/rv_mem_arbiter_pkg.sv
// Shared definitions for the iosys memory-port arbiter: address width,
// FSM state type, round-robin identifiers and the default abort data.
package rv_mem_arbiter_pkg;

    localparam int unsigned RV_AW            = 23;
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    localparam logic [1:0] RR_M1 = 2'd1;
    localparam logic [1:0] RR_M2 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        return idx;
    endfunction

endpackage

// File: rtl/rv_mem_arbiter_pick.sv
// Combinational winner selection: m0 has fixed priority, m1/m2 alternate
// starting from rr_next, falling back to the other one when rr_next is idle.
module rv_arb_pick
    import rv_mem_arbiter_pkg::*;
(
    input  logic [2:0] valids,
    input  logic [1:0] rr_next,
    output logic [2:0] winner
);

    always_comb begin
        winner = '0;
        if (valids[0]) begin
            winner = 3'b001;
        end else if (rr_next == RR_M2) begin
            if (valids[2])      winner = 3'b100;
            else if (valids[1]) winner = 3'b010;
        end else begin
            if (valids[1])      winner = 3'b010;
            else if (valids[2]) winner = 3'b100;
        end
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Three-master arbiter for the single iosys memory port, with a per-transaction
// timeout that aborts with ERR_DATA and a sticky error flag.
module rv_mem_arbiter
    import rv_mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 4096,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_valid,
    input  logic [RV_AW-1:0] m0_addr,
    input  logic [31:0]      m0_wdata,
    input  logic [3:0]       m0_wstrb,
    output logic             m0_ready,
    input  logic             m1_valid,
    input  logic [RV_AW-1:0] m1_addr,
    input  logic [31:0]      m1_wdata,
    input  logic [3:0]       m1_wstrb,
    output logic             m1_ready,
    input  logic             m2_valid,
    input  logic [RV_AW-1:0] m2_addr,
    input  logic [31:0]      m2_wdata,
    input  logic [3:0]       m2_wstrb,
    output logic             m2_ready,
    output logic [31:0]      m_rdata,
    output logic             rv_valid,
    output logic [RV_AW-1:0] rv_addr,
    output logic [31:0]      rv_wdata,
    output logic [3:0]       rv_wstrb,
    input  logic             rv_ready,
    input  logic [31:0]      rv_rdata,
    output logic [2:0]       grant,
    output logic             err,
    output logic [1:0]       err_port,
    input  logic             err_clr
);

    localparam int unsigned    TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

    arb_state_t       state;
    logic [TW-1:0]    tcnt;
    logic [1:0]       rr_next;
    logic [2:0]       ready_q;
    logic [2:0]       winner;
    logic [RV_AW-1:0] sel_addr;
    logic [31:0]      sel_wdata;
    logic [3:0]       sel_wstrb;

    rv_arb_pick u_pick (
        .valids  ({m2_valid, m1_valid, m0_valid}),
        .rr_next (rr_next),
        .winner  (winner)
    );

    always_comb begin
        sel_addr  = m0_addr;
        sel_wdata = m0_wdata;
        sel_wstrb = m0_wstrb;
        if (winner[1]) begin
            sel_addr  = m1_addr;
            sel_wdata = m1_wdata;
            sel_wstrb = m1_wstrb;
        end else if (winner[2]) begin
            sel_addr  = m2_addr;
            sel_wdata = m2_wdata;
            sel_wstrb = m2_wstrb;
        end
    end

    assign m0_ready = ready_q[0];
    assign m1_ready = ready_q[1];
    assign m2_ready = ready_q[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tcnt     <= '0;
            rr_next  <= RR_M1;
            ready_q  <= '0;
            grant    <= '0;
            rv_valid <= 1'b0;
            rv_addr  <= '0;
            rv_wdata <= '0;
            rv_wstrb <= '0;
            m_rdata  <= '0;
            err      <= 1'b0;
            err_port <= '0;
        end else begin
            ready_q <= '0;
            // A timeout later in this block overrides the clear.
            if (err_clr) err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|winner) begin
                        grant    <= winner;
                        rv_addr  <= sel_addr;
                        rv_wdata <= sel_wdata;
                        rv_wstrb <= sel_wstrb;
                        rv_valid <= 1'b1;
                        tcnt     <= '0;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (rv_ready) begin
                        m_rdata  <= rv_rdata;
                        rv_valid <= 1'b0;
                        ready_q  <= grant;
                        state    <= ST_RESP;
                    end else if (tcnt == TLAST) begin
                        m_rdata  <= ERR_DATA;
                        rv_valid <= 1'b0;
                        ready_q  <= grant;
                        err      <= 1'b1;
                        err_port <= onehot_to_idx(grant);
                        state    <= ST_RESP;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    grant <= '0;
                    if (grant[1])      rr_next <= RR_M2;
                    else if (grant[2]) rr_next <= RR_M1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: directed scenarios with literal expectations, then
// random traffic checked every cycle against a timestamp-based transaction model.
module tb_rv_mem_arbiter;

    localparam int unsigned TO   = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  valid;
    logic [22:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic [2:0]  ready_v;
    logic [31:0] m_rdata;
    logic        rv_valid;
    logic [22:0] rv_addr;
    logic [31:0] rv_wdata;
    logic [3:0]  rv_wstrb;
    logic        rv_ready;
    logic [31:0] rv_rdata;
    logic [2:0]  grant;
    logic        err;
    logic [1:0]  err_port;
    logic        err_clr;

    rv_mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(valid[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]), .m0_wstrb(wstrb[0]), .m0_ready(ready_v[0]),
        .m1_valid(valid[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]), .m1_wstrb(wstrb[1]), .m1_ready(ready_v[1]),
        .m2_valid(valid[2]), .m2_addr(addr[2]), .m2_wdata(wdata[2]), .m2_wstrb(wstrb[2]), .m2_ready(ready_v[2]),
        .m_rdata(m_rdata), .rv_valid(rv_valid), .rv_addr(rv_addr), .rv_wdata(rv_wdata),
        .rv_wstrb(rv_wstrb), .rv_ready(rv_ready), .rv_rdata(rv_rdata),
        .grant(grant), .err(err), .err_port(err_port), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: each grant opens a record stamped with the cycle its
    // request becomes visible and the cycle its ready pulse is shown.
    bit          mdl_active = 1'b0;
    int          t_start    = 0;
    int          t_done     = -1;
    int          cyc        = 0;
    int          rr         = 1;
    int          owner_idx  = 0;
    int          done_cnt   = 0;
    logic [2:0]  mdl_owner  = '0;
    logic [22:0] mdl_addr   = '0;
    logic [31:0] mdl_wdata  = '0;
    logic [3:0]  mdl_wstrb  = '0;
    logic [31:0] mdl_rdata  = '0;
    bit          mdl_err    = 1'b0;
    logic [1:0]  mdl_errp   = '0;

    always @(posedge clk or posedge reset) begin : mdl_upd
        bit to_now;
        int w;
        if (reset) begin
            mdl_active = 1'b0;
            t_done     = -1;
            rr         = 1;
            mdl_owner  = '0;
            mdl_addr   = '0;
            mdl_wdata  = '0;
            mdl_wstrb  = '0;
            mdl_rdata  = '0;
            mdl_err    = 1'b0;
            mdl_errp   = '0;
        end else begin
            to_now = 1'b0;
            w      = -1;
            if (!mdl_active || (t_done >= 0 && cyc > t_done)) begin
                if (valid[0])           w = 0;
                else if (valid[rr])     w = rr;
                else if (valid[3 - rr]) w = 3 - rr;
                if (w >= 0) begin
                    mdl_active = 1'b1;
                    t_start    = cyc + 1;
                    t_done     = -1;
                    owner_idx  = w;
                    mdl_owner  = '0;
                    mdl_owner[w] = 1'b1;
                    mdl_addr   = addr[w];
                    mdl_wdata  = wdata[w];
                    mdl_wstrb  = wstrb[w];
                end
            end else if (t_done < 0) begin
                if (rv_ready) begin
                    t_done    = cyc + 1;
                    mdl_rdata = rv_rdata;
                end else if (cyc - t_start == int'(TO) - 1) begin
                    t_done    = cyc + 1;
                    mdl_rdata = ERRD;
                    mdl_err   = 1'b1;
                    mdl_errp  = 2'(owner_idx);
                    to_now    = 1'b1;
                end
                if (t_done >= 0) begin
                    done_cnt++;
                    if (owner_idx != 0) rr = 3 - owner_idx;
                end
            end
            if (err_clr && !to_now) mdl_err = 1'b0;
            cyc++;
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge clk) begin : cmp
        logic [2:0] eg;
        logic [2:0] er;
        if (cmp_en && !reset) begin
            eg = (mdl_active && (t_done < 0 || cyc == t_done)) ? mdl_owner : 3'b000;
            er = (mdl_active && t_done >= 0 && cyc == t_done) ? mdl_owner : 3'b000;
            check("cyc_rv_valid", rv_valid, mdl_active && t_done < 0);
            check("cyc_grant",    grant,    eg);
            check("cyc_ready",    ready_v,  er);
            check("cyc_rv_addr",  rv_addr,  mdl_addr);
            check("cyc_rv_wdata", rv_wdata, mdl_wdata);
            check("cyc_rv_wstrb", rv_wstrb, mdl_wstrb);
            check("cyc_m_rdata",  m_rdata,  mdl_rdata);
            check("cyc_err",      err,      mdl_err);
            check("cyc_err_port", err_port, mdl_errp);
        end
    end

    // Single stimulus process: masters, downstream responder and err_clr.
    bit          auto_mode = 1'b0;
    bit          spur_once = 1'b0;
    bit [2:0]    hold      = '0;
    int          gap [3]   = '{0, 0, 0};
    int          rcnt      = 0;
    int          rdly      = 1;
    int          fixed_dly = 0;
    logic [31:0] dir_rdata = '0;

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (ready_v[i]) begin
                valid[i] = 1'b0;
                gap[i]   = $urandom_range(0, 4);
            end else if (valid[i]) begin
                if (auto_mode && $urandom_range(0, 1) == 1) begin
                    wdata[i] = $urandom;
                    addr[i]  = 23'($urandom);
                end
            end else if (hold[i]) begin
                valid[i] = 1'b1;
            end else if (auto_mode) begin
                if (gap[i] > 0) gap[i]--;
                else if (i != 0 || $urandom_range(0, 15) == 0) begin
                    valid[i] = 1'b1;
                    addr[i]  = 23'($urandom);
                    wdata[i] = $urandom;
                    wstrb[i] = 4'($urandom);
                end
            end
        end
        if (auto_mode) err_clr = ($urandom_range(0, 19) == 0);
        if (!rv_valid) begin
            rcnt      = 0;
            rv_ready  = spur_once || (auto_mode && $urandom_range(0, 15) == 0);
            spur_once = 1'b0;
        end else begin
            rcnt++;
            if (rcnt == 1) rdly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 20));
            rv_ready = (rcnt == rdly);
        end
        rv_rdata = auto_mode ? $urandom : dir_rdata;
    endtask

    int          vcnt;
    int          pc [3];
    logic [31:0] cap;
    logic [2:0]  order [$];
    logic [2:0]  exp_order [6];

    task automatic run_count(input int n);
        vcnt = 0;
        pc   = '{0, 0, 0};
        for (int k = 0; k < n; k++) begin
            step();
            if (rv_valid) vcnt++;
            for (int i = 0; i < 3; i++) if (ready_v[i]) begin
                pc[i]++;
                cap = m_rdata;
            end
        end
    endtask

    initial begin
        reset = 1'b1; valid = '0; err_clr = 1'b0; rv_ready = 1'b0; rv_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        check("rst_rv_valid", rv_valid, 1'b0);
        check("rst_grant",    grant,    3'b000);
        check("rst_ready",    ready_v,  3'b000);
        check("rst_m_rdata",  m_rdata,  32'h0);
        check("rst_err",      err,      1'b0);
        check("rst_err_port", err_port, 2'd0);

        // m1 read, downstream answers on the third request cycle
        valid[1] = 1'b1; addr[1] = 23'h000100; wstrb[1] = 4'h0;
        fixed_dly = 3; dir_rdata = 32'h1234_5678;
        run_count(12);
        check("t1_valid_cycles", vcnt, 3);
        check("t1_m1_pulses",    pc[1], 1);
        check("t1_m0_pulses",    pc[0], 0);
        check("t1_m2_pulses",    pc[2], 0);
        check("t1_rdata",        cap, 32'h1234_5678);

        // stray rv_ready while idle
        spur_once = 1'b1; dir_rdata = 32'h0BAD_0BAD;
        step(); step();
        check("t6_ready",   ready_v,  3'b000);
        check("t6_grant",   grant,    3'b000);
        check("t6_rv_valid", rv_valid, 1'b0);
        check("t6_m_rdata", m_rdata,  32'h1234_5678);

        // timeout on m1
        valid[1] = 1'b1; addr[1] = 23'h000200; fixed_dly = 1000;
        run_count(24);
        check("t4_valid_cycles", vcnt, 16);
        check("t4_m1_pulses",    pc[1], 1);
        check("t4_rdata",        cap, 32'hDEAD_BEEF);
        check("t4_err",          err, 1'b1);
        check("t4_err_port",     err_port, 2'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t4_err_cleared",  err, 1'b0);
        check("t4_err_port_kept", err_port, 2'd1);

        // m2 write; requester fields change while the request is in flight
        valid[2] = 1'b1; addr[2] = 23'h7F0004; wdata[2] = 32'hA5A5_A5A5; wstrb[2] = 4'b0100;
        fixed_dly = 4;
        step();
        check("t3_grant", grant, 3'b100);
        wdata[2] = 32'h0; addr[2] = 23'h0; wstrb[2] = 4'hF;
        step();
        check("t3_rv_addr",  rv_addr,  23'h7F0004);
        check("t3_rv_wdata", rv_wdata, 32'hA5A5_A5A5);
        check("t3_rv_wstrb", rv_wstrb, 4'b0100);
        run_count(8);
        check("t3_m2_pulses", pc[2], 1);

        // asynchronous reset in the middle of a request
        valid[1] = 1'b1; addr[1] = 23'h000300; fixed_dly = 1000;
        step(); step();
        reset = 1'b1;
        #1;
        check("t5_rv_valid_async", rv_valid, 1'b0);
        check("t5_grant_async",    grant,    3'b000);
        #1 reset = 1'b0;
        rcnt = 0; fixed_dly = 2;
        step();
        check("t5_regrant", grant, 3'b010);
        run_count(10);
        check("t5_m1_pulses", pc[1], 1);

        // simultaneous requests, then m1/m2 kept busy
        reset = 1'b1;
        #1 reset = 1'b0;
        fixed_dly = 1;
        valid = 3'b111; hold = 3'b110;
        for (int k = 0; k < 40 && order.size() < 6; k++) begin
            step();
            if (ready_v != 3'b000) order.push_back(ready_v);
        end
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b010, 3'b100, 3'b010};
        check("t2_order_len", order.size(), 6);
        for (int k = 0; k < 6 && k < order.size(); k++)
            check($sformatf("t2_order_%0d", k), order[k], exp_order[k]);
        hold = '0;
        repeat (10) step();

        // random traffic
        fixed_dly = 0; auto_mode = 1'b1;
        done_cnt = 0;
        repeat (3000) begin
            step();
            if (rv_valid && $urandom_range(0, 499) == 0) begin
                reset = 1'b1;
                #1;
                check("rnd_rv_valid_async", rv_valid, 1'b0);
                #1 reset = 1'b0;
                rcnt = 0;
            end
        end
        check("rnd_progress", done_cnt > 100, 1'b1);
        auto_mode = 1'b0;
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
